// File: rtl/vt_seq_detect_ctrl.sv
// Serial 6-bit pattern detector with a session controller (IDLE/RUN/DONE).
// Sessions end on a match target, a window of valid bits, or an abort.
module vt_seq_detect_ctrl (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cfg_we,
    input  logic [5:0] i_cfg_pattern,
    input  logic       i_cfg_ovl,
    input  logic [3:0] i_cfg_target,
    input  logic [7:0] i_cfg_window,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_SI,
    input  logic       i_SI_valid,
    output logic       o_busy,
    output logic       o_f,
    output logic       o_done,
    output logic       o_timeout,
    output logic [3:0] o_match_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] DEF_PATTERN = 6'b100110;

    logic [1:0] state;

    logic [5:0] cfg_pattern;
    logic       cfg_ovl;
    logic [3:0] cfg_target;
    logic [7:0] cfg_window;

    logic [5:0] history;
    logic [2:0] fill_cnt;
    logic [7:0] win_cnt;

    logic [5:0] shifted;
    logic       consume;
    logic       match;
    logic [3:0] cnt_next;
    logic [2:0] fill_next;
    logic [7:0] win_next;
    logic       target_hit;
    logic       window_hit;

    function automatic logic [3:0] sat_inc_cnt(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    function automatic logic [2:0] sat_inc_fill(input logic [2:0] v);
        return (v >= 3'd6) ? 3'd6 : v + 3'd1;
    endfunction

    function automatic logic [7:0] sat_inc_win(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A match needs five history bits already present plus the incoming bit.
    always_comb begin
        shifted    = {history[4:0], i_SI};
        consume    = (state == ST_RUN) && i_SI_valid && !i_abort;
        match      = consume && (fill_cnt >= 3'd5) && (shifted == cfg_pattern);
        cnt_next   = match ? sat_inc_cnt(o_match_cnt) : o_match_cnt;
        fill_next  = (match && !cfg_ovl) ? 3'd0 : sat_inc_fill(fill_cnt);
        win_next   = sat_inc_win(win_cnt);
        target_hit = match && (cfg_target != 4'd0) && (cnt_next == cfg_target);
        window_hit = consume && (cfg_window != 8'd0) && (win_next == cfg_window);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            cfg_pattern <= DEF_PATTERN;
            cfg_ovl     <= 1'b1;
            cfg_target  <= 4'd1;
            cfg_window  <= 8'd0;
            history     <= 6'd0;
            fill_cnt    <= 3'd0;
            win_cnt     <= 8'd0;
            o_busy      <= 1'b0;
            o_f         <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_match_cnt <= 4'd0;
        end else begin
            o_f    <= 1'b0;
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cfg_we) begin
                        cfg_pattern <= i_cfg_pattern;
                        cfg_ovl     <= i_cfg_ovl;
                        cfg_target  <= i_cfg_target;
                        cfg_window  <= i_cfg_window;
                    end
                    if (i_start) begin
                        history     <= 6'd0;
                        fill_cnt    <= 3'd0;
                        win_cnt     <= 8'd0;
                        o_match_cnt <= 4'd0;
                        o_timeout   <= 1'b0;
                        o_busy      <= 1'b1;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        state     <= ST_DONE;
                    end else if (i_SI_valid) begin
                        history     <= shifted;
                        fill_cnt    <= fill_next;
                        win_cnt     <= win_next;
                        o_match_cnt <= cnt_next;
                        o_f         <= match;
                        // Target wins a tie with the window on the same bit.
                        if (target_hit || window_hit) begin
                            o_timeout <= !target_hit;
                            o_busy    <= 1'b0;
                            o_done    <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vt_seq_detect_ctrl.sv
// Directed, table-driven bench for vt_seq_detect_ctrl plus hand sequences
// for the valid-gap and mid-session reset cases.
module tb_vt_seq_detect_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_cfg_we;
    logic [5:0] i_cfg_pattern;
    logic       i_cfg_ovl;
    logic [3:0] i_cfg_target;
    logic [7:0] i_cfg_window;
    logic       i_start;
    logic       i_abort;
    logic       i_SI;
    logic       i_SI_valid;
    logic       o_busy;
    logic       o_f;
    logic       o_done;
    logic       o_timeout;
    logic [3:0] o_match_cnt;

    vt_seq_detect_ctrl dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_cfg_we      (i_cfg_we),
        .i_cfg_pattern (i_cfg_pattern),
        .i_cfg_ovl     (i_cfg_ovl),
        .i_cfg_target  (i_cfg_target),
        .i_cfg_window  (i_cfg_window),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_SI          (i_SI),
        .i_SI_valid    (i_SI_valid),
        .o_busy        (o_busy),
        .o_f           (o_f),
        .o_done        (o_done),
        .o_timeout     (o_timeout),
        .o_match_cnt   (o_match_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       st;
        logic       we;
        logic [5:0] pat;
        logic       ovl;
        logic [3:0] tgt;
        logic [7:0] win;
        logic       ab;
        logic       si;
        logic       siv;
        logic       ef;
        logic       ed;
        logic       eb;
        logic       eto;
        logic [3:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%b required=%b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic add(input logic st, input logic we, input logic [5:0] pat, input logic ovl,
                       input logic [3:0] tgt, input logic [7:0] win, input logic ab,
                       input logic si, input logic siv, input logic ef, input logic ed,
                       input logic eb, input logic eto, input logic [3:0] ec);
        vec_t v;
        v.st = st; v.we = we; v.pat = pat; v.ovl = ovl; v.tgt = tgt; v.win = win;
        v.ab = ab; v.si = si; v.siv = siv;
        v.ef = ef; v.ed = ed; v.eb = eb; v.eto = eto; v.ec = ec;
        vecs.push_back(v);
    endtask

    // One valid serial bit in RUN, with the outputs expected after its edge.
    task automatic bitv(input logic si, input logic ef, input logic ed, input logic eb,
                        input logic eto, input logic [3:0] ec);
        add(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, si, 1, ef, ed, eb, eto, ec);
    endtask

    task automatic drive(input logic st, input logic we, input logic [5:0] pat, input logic ovl,
                         input logic [3:0] tgt, input logic [7:0] win, input logic ab,
                         input logic si, input logic siv);
        i_start = st; i_cfg_we = we; i_cfg_pattern = pat; i_cfg_ovl = ovl;
        i_cfg_target = tgt; i_cfg_window = win; i_abort = ab; i_SI = si; i_SI_valid = siv;
    endtask

    function automatic logic [7:0] outs();
        return {o_f, o_done, o_busy, o_timeout, o_match_cnt};
    endfunction

    initial begin
        int nf;
        logic done_seen;
        logic [5:0] pat;

        // Overlap: target 2, matches at bits 6 and 10.
        add(1, 1, 6'b100110, 1, 4'd2, 8'd0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 1, 0, 1, 0, 4'd1);
        bitv(0, 0, 0, 1, 0, 4'd1); bitv(1, 0, 0, 1, 0, 4'd1); bitv(1, 0, 0, 1, 0, 4'd1);
        bitv(0, 1, 1, 0, 0, 4'd2);
        add(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 4'd2);
        // Non-overlap, window 12; the valid bit in the start cycle must not count.
        add(1, 1, 6'b100110, 0, 4'd2, 8'd12, 0, 1, 1, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 1, 0, 1, 0, 4'd1);
        bitv(0, 0, 0, 1, 0, 4'd1); bitv(1, 0, 0, 1, 0, 4'd1); bitv(1, 0, 0, 1, 0, 4'd1);
        bitv(0, 0, 0, 1, 0, 4'd1); bitv(0, 0, 0, 1, 0, 4'd1); bitv(0, 0, 1, 0, 1, 4'd1);
        add(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 1, 1, 0, 0, 0, 1, 4'd1);
        // Tie: target 1 and window 6 met on bit 6 -> success.
        add(1, 1, 6'b100110, 1, 4'd1, 8'd6, 0, 0, 0, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 1, 1, 0, 0, 4'd1);
        add(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 4'd1);
        // Config write and start during RUN are ignored.
        add(1, 1, 6'b100110, 1, 4'd1, 8'd0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
        add(1, 1, 6'b111111, 0, 4'd0, 8'd0, 0, 1, 1, 0, 0, 1, 0, 4'd0);
        bitv(0, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 1, 1, 0, 0, 4'd1);
        add(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 4'd1);
        // Unlimited session ends only on abort; the abort-cycle bit would complete a match.
        add(1, 1, 6'b100110, 1, 4'd0, 8'd0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0); bitv(0, 0, 0, 1, 0, 4'd0);
        bitv(1, 0, 0, 1, 0, 4'd0); bitv(1, 0, 0, 1, 0, 4'd0); bitv(0, 1, 0, 1, 0, 4'd1);
        bitv(0, 0, 0, 1, 0, 4'd1); bitv(1, 0, 0, 1, 0, 4'd1); bitv(1, 0, 0, 1, 0, 4'd1);
        add(0, 0, 6'd0, 0, 4'd0, 8'd0, 1, 0, 1, 0, 1, 0, 1, 4'd1);
        add(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0, 0, 0, 0, 1, 4'd1);

        drive(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0);
        i_rst_n = 1'b0;
        tick(); tick();
        check("reset_outputs", outs(), 8'b0000_0000);
        i_rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].we, vecs[i].pat, vecs[i].ovl, vecs[i].tgt,
                  vecs[i].win, vecs[i].ab, vecs[i].si, vecs[i].siv);
            tick();
            check($sformatf("row%0d", i), outs(),
                  {vecs[i].ef, vecs[i].ed, vecs[i].eb, vecs[i].eto, vecs[i].ec});
        end

        // Valid gaps with garbage on i_SI between the pattern bits.
        drive(1, 1, 6'b100110, 1, 4'd1, 8'd0, 0, 0, 0);
        tick();
        nf = 0;
        done_seen = 1'b0;
        pat = 6'b100110;
        for (int b = 5; b >= 0; b--) begin
            for (int g = 0; g < 3; g++) begin
                drive(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 1'($urandom), 0);
                tick();
                nf += int'(o_f);
                done_seen |= o_done;
            end
            drive(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, pat[b], 1);
            tick();
            nf += int'(o_f);
            done_seen |= o_done;
        end
        drive(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0);
        check("gap_f_pulses", 8'(nf), 8'd1);
        check("gap_cnt_done", {3'd0, done_seen, o_match_cnt}, {3'd0, 1'b1, 4'd1});
        tick(); tick();

        // Mid-session reset after 3 bits must restore the default config.
        drive(0, 1, 6'b111111, 0, 4'd3, 8'd9, 0, 0, 0);
        tick();
        drive(1, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0);
        tick();
        for (int b = 0; b < 3; b++) begin
            drive(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 1, 1);
            tick();
        end
        check("pre_reset_busy", outs(), 8'b0010_0000);
        #2 i_rst_n = 1'b0;
        #1 check("async_reset_outputs", outs(), 8'b0000_0000);
        drive(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0);
        tick();
        i_rst_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            done_seen |= o_done;
        end
        check("no_done_after_reset", {7'd0, done_seen}, 8'd0);
        drive(1, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0);
        tick();
        for (int b = 5; b >= 0; b--) begin
            drive(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, pat[b], 1);
            tick();
        end
        check("default_cfg_session", outs(), 8'b1100_0001);
        drive(0, 0, 6'd0, 0, 4'd0, 8'd0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vt_seq_detect_ctrl.md
VT_SEQ_DETECT_CTRL -- requirements
Module: vt_seq_detect_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_cfg_we  input  1  config write strobe; accepted only in IDLE.
REQ-005 i_cfg_pattern  input  6  target pattern; MSB is the oldest bit.
REQ-006 i_cfg_ovl  input  1  1 = overlapping detection; 0 = non-overlapping.
REQ-007 i_cfg_target  input  4  matches that end a session; 0 = unlimited.
REQ-008 i_cfg_window  input  8  max valid bits per session; 0 = unlimited.
REQ-009 i_start  input  1  session start; accepted only in IDLE.
REQ-010 i_abort  input  1  ends a RUN session at the next edge.
REQ-011 i_SI  input  1  serial data bit.
REQ-012 i_SI_valid  input  1  qualifies i_SI; the bit is consumed only in RUN.
REQ-013 o_busy  output  1  high in RUN.
REQ-014 o_f  output  1  registered one-cycle match pulse.
REQ-015 o_done  output  1  registered one-cycle session-end pulse.
REQ-016 o_timeout  output  1  session ended by window or abort; held until next accepted start.
REQ-017 o_match_cnt  output  4  matches this session; saturates at 15; held until next accepted start.

Function
REQ-018 FSM SHALL have states IDLE, RUN and DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-019 IDLE with i_cfg_we=1: config registers SHALL load at the edge; i_cfg_we outside IDLE SHALL be ignored.
REQ-020 IDLE with i_start=1: the block SHALL clear the history, fill count, window count, o_match_cnt and o_timeout, then enter RUN at the next edge.
REQ-021 If i_cfg_we and i_start are both high in IDLE, the config SHALL load and the session SHALL use the new config.
REQ-022 i_SI_valid in the start cycle, or in IDLE or DONE, SHALL be ignored; i_start outside IDLE SHALL be ignored.
REQ-023 RUN, each valid bit: history <= {history[4:0], i_SI}; fill count increments, saturating at 6; window count increments.
REQ-024 Match SHALL be {history[4:0], i_SI} == pattern with fill count >= 5 before the bit is consumed.
REQ-025 On a match, o_f SHALL be high for the single cycle after the matching bit's edge, and o_match_cnt SHALL increment, saturating at 15.
REQ-026 Overlap mode SHALL keep the history after a match; non-overlap mode SHALL reset the fill count to 0 after a match.
REQ-027 If the match count reaches a nonzero target, the FSM SHALL go RUN->DONE with o_timeout=0.
REQ-028 If the window count reaches a nonzero window without the target being met, the FSM SHALL go RUN->DONE with o_timeout=1.
REQ-029 If the target and the window are met on the same bit, the result SHALL be success (o_timeout=0).
REQ-030 i_abort in RUN SHALL force DONE with o_timeout=1; a bit presented in the abort cycle SHALL be ignored.
REQ-031 o_done SHALL pulse high for one cycle while in DONE.
REQ-032 Cycles with i_SI_valid=0 SHALL leave the history and all counts unchanged.
REQ-033 With target=0 and window=0, the session SHALL end only on i_abort.

Reset
REQ-034 While i_rst_n=0, the block SHALL asynchronously set: state IDLE; o_busy, o_f, o_done and o_timeout to 0; o_match_cnt to 0; history and all counts to 0.
REQ-035 Reset SHALL set the config registers to pattern 6'b100110, ovl=1, target=1 and window=0.
REQ-036 A reset asserted during RUN SHALL abandon the session without an o_done pulse.

Verification
REQ-037 Overlap: pattern 100110, ovl=1, target=2, window=0; stream 1,0,0,1,1,0,0,1,1,0 (all valid) -> o_f after bits 6 and 10; o_done after bit 10; cnt=2; timeout=0.
REQ-038 Non-overlap: same stream with ovl=0, target=2, window=12, then bits 0,0 -> one o_f (bit 6); o_done after bit 12; timeout=1; cnt=1.
REQ-039 Valid gaps: stream 100110 with i_SI_valid=0 for 3 cycles between each bit and garbage on i_SI -> exactly one o_f; cnt=1.
REQ-040 Tie: target=1, window=6; stream 100110 -> o_done after bit 6 with timeout=0.
REQ-041 Drop i_rst_n mid-RUN after 3 bits -> all outputs 0 immediately; no o_done; pattern reads back as 100110 (a subsequent session with defaults matches 100110).
REQ-042 Pulse i_cfg_we (pattern 111111) and i_start during RUN -> both ignored; session completes on the original pattern.
